polyveck_pack_eta: RTL and testbench
====================================

POLYVECK_PACK_ETA -- requirements
Module: polyveck_pack_eta

Interface
REQ-001 Parameter K, default 6, number of polynomials in the vector; the architecture is fixed at K=6.
REQ-002 Parameter ETA, default 4, coefficient bound; the architecture is fixed at ETA=4.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port rtr, input, 1 bit: request to run; must stay high until rts is seen high.
REQ-006 Port linear_v, input, 49152 bits: K polys × 256 coeffs × 32 bits; poly p coeff j at bits [8192p+32j+31 : 8192p+32j], signed two's complement.
REQ-007 Port linear_packed, output, 6144 bits: packed vector; poly p coeff j nibble at bits [1024p+4j+3 : 1024p+4j].
REQ-008 Port rts, output, 1 bit: ready to send; linear_packed is valid while rts is high.
REQ-009 Port error, output, 1 bit: sticky out-of-range flag for the current run.

Function
REQ-010 FSM states: IDLE, WAIT_RTR, INIT, PACK, DONE; the state register resets to IDLE.
REQ-011 IDLE goes to WAIT_RTR unconditionally on the next edge.
REQ-012 WAIT_RTR goes to INIT when rtr=1 and stays otherwise.
REQ-013 INIT goes to PACK; in INIT, chunk counter c (7 bits) ← 0 and error ← 0.
REQ-014 PACK processes one chunk per cycle, c = 0..95, with p = c[6:4] and s = c[3:0].
REQ-015 Each PACK chunk handles coeffs 16s..16s+15 of poly p and writes bits [1024p+64s+63 : 1024p+64s].
REQ-016 In PACK, c increments; at c=95 the FSM goes to DONE and c does not wrap.
REQ-017 Each nibble written = low 4 bits of (ETA − a), where a is the signed 32-bit coefficient.
REQ-018 Legal a in [−4, 4] maps to nibble 8..0.
REQ-019 rts=1 iff state=DONE; rts is decoded from registered state only, with no combinational path from rtr.
REQ-020 DONE stays while rtr=1 and goes to IDLE when rtr=0; linear_packed and error hold their values through DONE and IDLE.
REQ-021 Latency: if rtr is sampled high at edge N in WAIT_RTR, INIT runs at N+1 and the last chunk is written at N+97, when DONE is entered; rts is high after edge N+97.
REQ-022 Handshake: linear_v must be stable from the edge where rtr is sampled high until rts is high.
REQ-023 The block does not register linear_v; it reads linear_v live during PACK.
REQ-024 rtr dropping during INIT or PACK is ignored and the run completes.
REQ-025 If rtr is already low on DONE entry, rts is high for exactly one cycle, then IDLE.
REQ-026 A new run requires passing through IDLE and WAIT_RTR, so the minimum gap from rts falling to the next INIT is 2 cycles.
REQ-027 linear_packed bits not yet written in a run keep their previous-run values until overwritten; all bits are overwritten before rts rises.

Reset
REQ-028 While reset=1 at an edge: state ← IDLE, c ← 0, linear_packed ← 0, error ← 0; rts=0 in the following cycle.
REQ-029 Reset mid-PACK or in DONE aborts the run with no partial-output guarantee beyond the zeros of REQ-028.
REQ-030 Reset has priority over every other transition.

Configuration
REQ-031 Macro PACK_ETA_RANGE_CHECK_EN, when defined, enables the range check.
REQ-032 With PACK_ETA_RANGE_CHECK_EN defined: any PACK-cycle coeff with a < −4 or a > 4 sets error ← 1 on that edge, and error stays set until the next INIT or reset.
REQ-033 With PACK_ETA_RANGE_CHECK_EN defined: packing of an illegal coeff still uses the low 4 bits of (4 − a).
REQ-034 With PACK_ETA_RANGE_CHECK_EN undefined: error is constant 0, no comparator logic is built, and packing is identical.

Verification
REQ-035 All coeffs 0, rtr pulsed high → rts rises after exactly 97 edges from the rtr sample; linear_packed is all 0x4 nibbles; error=0.
REQ-036 All coeffs −4 (0xFFFFFFFC) → all nibbles 0x8; all coeffs +4 → linear_packed all zero.
REQ-037 Poly p coeff j = ((p+j) mod 9) − 4 → nibble j of poly p equals 8 − ((p+j) mod 9) for all 1536 nibbles.
REQ-038 Poly 3 coeff 17 = 5, others 0 → error=1 at rts with the macro defined, 0 without; bits [3143:3140] = 0xF in both builds.
REQ-039 Reset asserted at c=40 → next cycle rts=0, linear_packed=0, error=0; a following rtr pulse completes a normal run.
REQ-040 rtr held high 10 cycles past rts → rts stays high; rtr drop → rts low next cycle, and a second run with new data overwrites all bits and clears a prior error.

Source files
------------

// File: rtl/polyveck_pack_eta.sv
// Packs a K=6 polynomial vector of signed coefficients into 4-bit (ETA - a) nibbles, one 16-coeff chunk per cycle.
// Define PACK_ETA_RANGE_CHECK_EN to build the sticky out-of-range error flag; otherwise error is tied low.
module polyveck_pack_eta #(
    parameter int K   = 6,
    parameter int ETA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rtr,
    input  logic [K*8192-1:0]  linear_v,
    output logic [K*1024-1:0]  linear_packed,
    output logic               rts,
    output logic               error
);

    typedef enum logic [2:0] {IDLE, WAIT_RTR, INIT, PACK, DONE} state_t;

    state_t              state_q, state_d;
    logic [6:0]          c_q, c_d;
    logic [K*1024-1:0]   packed_q, packed_d;
    logic [2:0]          p_w;
    logic [3:0]          s_w;
    logic [63:0]         chunk_w;

    function automatic logic [3:0] pack_nib(input logic signed [31:0] a);
        logic signed [31:0] d;
        d = ETA - a;
        return d[3:0];
    endfunction

`ifdef PACK_ETA_RANGE_CHECK_EN
    logic err_q, err_d;
    logic bad_w;

    function automatic logic out_of_range(input logic signed [31:0] a);
        return (a < -ETA) || (a > ETA);
    endfunction
`endif

    assign p_w = c_q[6:4];
    assign s_w = c_q[3:0];

    // linear_v is read live: bit offset 8192p + 512s + 32i is just {p, s, i, 5'b0}
    always_comb begin
        chunk_w = '0;
`ifdef PACK_ETA_RANGE_CHECK_EN
        bad_w   = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            chunk_w[4*i +: 4] = pack_nib(linear_v[{p_w, s_w, i[3:0], 5'b0} +: 32]);
`ifdef PACK_ETA_RANGE_CHECK_EN
            bad_w = bad_w | out_of_range(linear_v[{p_w, s_w, i[3:0], 5'b0} +: 32]);
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        packed_d = packed_q;
`ifdef PACK_ETA_RANGE_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE:     state_d = WAIT_RTR;
            WAIT_RTR: if (rtr) state_d = INIT;
            INIT: begin
                c_d     = '0;
`ifdef PACK_ETA_RANGE_CHECK_EN
                err_d   = 1'b0;
`endif
                state_d = PACK;
            end
            PACK: begin
                packed_d[{p_w, s_w, 6'b0} +: 64] = chunk_w;
`ifdef PACK_ETA_RANGE_CHECK_EN
                err_d = err_q | bad_w;
`endif
                // c saturates at the last chunk; rtr is ignored until DONE
                if (c_q == 7'd95) state_d = DONE;
                else              c_d     = c_q + 7'd1;
            end
            DONE:     if (!rtr) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            c_q      <= '0;
            packed_q <= '0;
`ifdef PACK_ETA_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            packed_q <= packed_d;
`ifdef PACK_ETA_RANGE_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign linear_packed = packed_q;
    assign rts           = (state_q == DONE);
`ifdef PACK_ETA_RANGE_CHECK_EN
    assign error         = err_q;
`else
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_polyveck_pack_eta.sv
// Self-checking bench for polyveck_pack_eta: random and directed vectors against a behavioural packing model.
// Honours PACK_ETA_RANGE_CHECK_EN so the expected error flag matches the build.
module tb_polyveck_pack_eta;

    logic           clock = 1'b0;
    logic           reset;
    logic           rtr;
    logic [49151:0] lv;
    logic [6143:0]  linear_packed;
    logic           rts;
    logic           error;

    logic [6143:0]  exp_packed;
    logic           exp_err;
    int             checks   = 0;
    int             failures = 0;

    polyveck_pack_eta #(.K(6), .ETA(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .rtr          (rtr),
        .linear_v     (lv),
        .linear_packed(linear_packed),
        .rts          (rts),
        .error        (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic chk_vec(input string name, input logic [6143:0] act, input logic [6143:0] want);
        checks++;
        if (act !== want) begin
            int n;
            n = 0;
            for (int k = 0; k < 1536; k++)
                if (act[4*k +: 4] !== want[4*k +: 4]) begin n = k; break; end
            failures++;
            $display("FAIL %s: nibble %0d got %h expected %h", name, n, act[4*n +: 4], want[4*n +: 4]);
        end
    endtask

    // Model: nibble = (4 - a) mod 16; error = any coefficient outside [-4, 4] when the check is built.
    task automatic update_model();
        logic signed [31:0] a;
        int d;
        exp_packed = '0;
        exp_err    = 1'b0;
        for (int p = 0; p < 6; p++)
            for (int j = 0; j < 256; j++) begin
                a = lv[8192*p + 32*j +: 32];
                d = 4 - a;
                exp_packed[1024*p + 4*j +: 4] = d[3:0];
`ifdef PACK_ETA_RANGE_CHECK_EN
                if (a < -4 || a > 4) exp_err = 1'b1;
`endif
            end
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int k = 0; k < 1536; k++) lv[32*k +: 32] = v;
        update_model();
    endtask

    task automatic fill_random(input int bad_pct);
        logic [31:0] v;
        for (int k = 0; k < 1536; k++) begin
            if ($urandom_range(0, 99) < bad_pct) v = $urandom();
            else                                 v = $urandom_range(0, 8) - 4;
            lv[32*k +: 32] = v;
        end
        update_model();
    endtask

    // Outputs are meaningful whenever rts is high: compare against the model every such cycle.
    always @(negedge clock) begin
        if (!reset && rts) begin
            chk_vec("packed_at_rts", linear_packed, exp_packed);
            chk("error_at_rts", error, exp_err);
        end
    end

    // Expects the DUT to be in WAIT_RTR; checks 97-edge latency and the rts fall.
    task automatic run(input int hold_extra, input bit drop_early);
        int cyc;
        bit seen;
        @(negedge clock);
        rtr  = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            if (drop_early && cyc == 5) rtr = 1'b0;
            seen = rts;
        end
        chk("latency", cyc - 1, 97);
        if (!seen) begin
            rtr = 1'b0;
            repeat (3) @(posedge clock);
            return;
        end
        if (!drop_early) begin
            repeat (hold_extra) begin
                @(posedge clock); #1;
                chk("rts_hold", rts, 1);
            end
            rtr = 1'b0;
        end
        @(posedge clock); #1;
        chk("rts_fall", rts, 0);
        chk_vec("hold_idle", linear_packed, exp_packed);
        chk("err_idle", error, exp_err);
        @(posedge clock);
    endtask

    initial begin
        int bad;
        logic [6143:0] lit;
        reset = 1'b1;
        rtr   = 1'b0;
        lv    = '0;
        repeat (3) @(posedge clock); #1;
        chk("reset_rts", rts, 0);
        chk("reset_err", error, 0);
        lit = '0;
        chk_vec("reset_packed", linear_packed, lit);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        set_all(32'd0);
        run(0, 1'b1);
        lit = {1536{4'h4}};
        chk_vec("zeros_literal", linear_packed, lit);
        chk("zeros_err", error, 0);

        set_all(32'hFFFF_FFFC);
        run(1, 1'b0);
        lit = {1536{4'h8}};
        chk_vec("minus4_literal", linear_packed, lit);

        set_all(32'd4);
        run(0, 1'b0);
        lit = '0;
        chk_vec("plus4_literal", linear_packed, lit);

        for (int p = 0; p < 6; p++)
            for (int j = 0; j < 256; j++)
                lv[8192*p + 32*j +: 32] = ((p + j) % 9) - 4;
        update_model();
        run(2, 1'b0);
        for (int p = 0; p < 6; p++) begin
            bad = 0;
            for (int j = 0; j < 256; j++)
                if (linear_packed[1024*p + 4*j +: 4] != 4'(8 - ((p + j) % 9))) bad++;
            chk("ramp_poly_bad_nibbles", bad, 0);
        end

        set_all(32'd0);
        lv[8192*3 + 32*17 +: 32] = 32'd5;
        update_model();
        run(10, 1'b0);
        lit[3:0] = linear_packed[3143:3140];
        chk("p3c17_nibble", lit[3:0], 15);
`ifdef PACK_ETA_RANGE_CHECK_EN
        chk("p3c17_error", error, 1);
`else
        chk("p3c17_error", error, 0);
`endif

        fill_random(0);
        run(0, 1'b0);
        chk("second_run_err_cleared", error, 0);

        set_all(32'd0);
        lv[31:0] = 32'd7;
        update_model();
        @(negedge clock);
        rtr = 1'b1;
        repeat (42) @(posedge clock);
        #1;
        reset = 1'b1;
        rtr   = 1'b0;
        @(posedge clock); #1;
        chk("midreset_rts", rts, 0);
        chk("midreset_err", error, 0);
        lit = '0;
        chk_vec("midreset_packed", linear_packed, lit);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        fill_random(0);
        run(0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            fill_random((r % 3 == 0) ? 20 : 0);
            run(r % 3, r % 2 == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
